// File: rtl/unimem.sv
// unimem: Unibus slave memory answering DATI/DATIP/DATO/DATOB from an internal 16-bit RAM,
// with ARM register access and a backdoor word path. Define UNIMEM_COUNTERS_EN for cycle counters at reg 4.
module unimem #(
    parameter logic [17:0] BASE    = 18'o000000,
    parameter int          NWORDS  = 4096,
    parameter int          DESKEW  = 8,
    parameter int          SSYNDLY = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    input  logic        msyn_in_h,
    input  logic        init_in_h,
    output logic [15:0] d_out_h,
    output logic        ssyn_out_h
);

    localparam int          AW          = $clog2(NWORDS);
    localparam logic [18:0] WIN_LO      = {1'b0, BASE};
    localparam logic [18:0] WIN_HI      = WIN_LO + 19'(2 * NWORDS) - 19'd2;
    localparam logic [17:0] AMASK       = 18'(NWORDS - 1);
    localparam logic [15:0] DESKEW_LAST = 16'(DESKEW - 1);
    localparam logic [15:0] SSYN_LAST   = 16'(SSYNDLY - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_DESKEW, ST_READ, ST_DRIVE, ST_WRITE, ST_HOLD, ST_MISS
    } state_t;

    state_t         state_r, state_n_s;
    logic [15:0]    cnt_r, cnt_n_s;
    logic [15:0]    d_out_r, d_out_n_s;
    logic           ssyn_r, ssyn_n_s;
    logic           start_s, latch_s, bd_go_s;
    logic           cyc_en_r, hit_r, hit_s;
    logic [AW-1:0]  lat_idx_r;
    logic           lat_hi_r, lat_dob_r;
    logic [15:0]    lat_d_r;
    logic [18:0]    a_even_s;
    logic [17:0]    a_off_s;
    logic [1:0]     write_be_s;

    logic [15:0]    mem_r [NWORDS];
    logic [15:0]    ram_q_r;
    logic           ram_we_s;
    logic [1:0]     ram_be_s;
    logic [AW-1:0]  ram_waddr_s, ram_raddr_s;
    logic [15:0]    ram_wdata_s;

    logic           enable_r, armpend_r, armdir_r, bd_rd_r;
    logic [17:0]    armaddr_r;
    logic [15:0]    armdata_r;
    logic           unused_s;

    // Window check uses the word-aligned address so odd byte addresses of the top word still hit
    assign a_even_s   = {1'b0, a_in_h[17:1], 1'b0};
    assign a_off_s    = a_in_h - BASE;
    assign hit_s      = cyc_en_r && (a_even_s >= WIN_LO) && (a_even_s <= WIN_HI);
    assign write_be_s = !lat_dob_r ? 2'b11 : (lat_hi_r ? 2'b10 : 2'b01);
    assign unused_s   = ^{armwdata[30:18], a_off_s[17:AW+1], a_off_s[0]};
    assign d_out_h    = d_out_r;
    assign ssyn_out_h = ssyn_r;

    // Bus-cycle sequencer: next state, handshake outputs and RAM port control
    always_comb begin
        state_n_s   = state_r;
        cnt_n_s     = cnt_r;
        d_out_n_s   = d_out_r;
        ssyn_n_s    = ssyn_r;
        start_s     = 1'b0;
        latch_s     = 1'b0;
        bd_go_s     = 1'b0;
        ram_we_s    = 1'b0;
        ram_be_s    = 2'b11;
        ram_waddr_s = lat_idx_r;
        ram_raddr_s = lat_idx_r;
        ram_wdata_s = lat_d_r;
        if (init_in_h) begin
            // A write already in WRITE still lands; everything else is abandoned
            state_n_s = ST_IDLE;
            cnt_n_s   = 16'd0;
            d_out_n_s = 16'd0;
            ssyn_n_s  = 1'b0;
            ram_we_s  = (state_r == ST_WRITE);
            ram_be_s  = write_be_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (msyn_in_h) begin
                        state_n_s = ST_DESKEW;
                        cnt_n_s   = 16'd0;
                        start_s   = 1'b1;
                    end else if (armpend_r) begin
                        bd_go_s     = 1'b1;
                        ram_raddr_s = armaddr_r[AW-1:0];
                        ram_waddr_s = armaddr_r[AW-1:0];
                        ram_wdata_s = armdata_r;
                        ram_we_s    = armdir_r;
                    end else begin
                        bd_go_s = 1'b0;
                    end
                end
                ST_DESKEW: begin
                    if (!msyn_in_h) begin
                        state_n_s = ST_IDLE;
                    end else if (cnt_r == DESKEW_LAST) begin
                        latch_s   = 1'b1;
                        cnt_n_s   = 16'd0;
                        state_n_s = hit_s ? (c_in_h[1] ? ST_WRITE : ST_READ) : ST_MISS;
                    end else begin
                        cnt_n_s = cnt_r + 16'd1;
                    end
                end
                ST_READ: begin
                    if (cnt_r == 16'd0) begin
                        cnt_n_s = 16'd1;
                    end else begin
                        d_out_n_s = ram_q_r;
                        cnt_n_s   = 16'd0;
                        state_n_s = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r == SSYN_LAST) begin
                        ssyn_n_s  = 1'b1;
                        state_n_s = ST_HOLD;
                    end else begin
                        cnt_n_s = cnt_r + 16'd1;
                    end
                end
                ST_WRITE: begin
                    ram_we_s  = 1'b1;
                    ram_be_s  = write_be_s;
                    ssyn_n_s  = 1'b1;
                    state_n_s = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!msyn_in_h) begin
                        d_out_n_s = 16'd0;
                        ssyn_n_s  = 1'b0;
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = ST_HOLD;
                    end
                end
                ST_MISS: begin
                    if (!msyn_in_h) begin
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = ST_MISS;
                    end
                end
                default: state_n_s = ST_IDLE;
            endcase
        end
    end

    // Sequencer state, bus outputs and the latched bus cycle
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            d_out_r   <= 16'd0;
            ssyn_r    <= 1'b0;
            cyc_en_r  <= 1'b0;
            hit_r     <= 1'b0;
            lat_idx_r <= '0;
            lat_hi_r  <= 1'b0;
            lat_dob_r <= 1'b0;
            lat_d_r   <= 16'd0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            d_out_r <= d_out_n_s;
            ssyn_r  <= ssyn_n_s;
            // Enable is sampled at MSYN so clearing it mid-cycle only affects later cycles
            if (start_s) cyc_en_r <= enable_r;
            if (latch_s) begin
                lat_idx_r <= a_off_s[AW:1];
                lat_hi_r  <= a_in_h[0];
                lat_dob_r <= c_in_h[0];
                lat_d_r   <= d_in_h;
                hit_r     <= hit_s;
            end
        end
    end

    // Shared RAM: byte-lane write port and registered read port
    always_ff @(posedge CLOCK) begin
        if (RESET && ram_we_s) begin
            if (ram_be_s[0]) mem_r[ram_waddr_s][7:0]  <= ram_wdata_s[7:0];
            if (ram_be_s[1]) mem_r[ram_waddr_s][15:8] <= ram_wdata_s[15:8];
        end
        ram_q_r <= mem_r[ram_raddr_s];
    end

    // ARM registers and backdoor request tracking
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            enable_r  <= 1'b0;
            armpend_r <= 1'b0;
            armdir_r  <= 1'b0;
            armaddr_r <= 18'd0;
            armdata_r <= 16'd0;
            bd_rd_r   <= 1'b0;
        end else begin
            bd_rd_r <= bd_go_s && !armdir_r;
            if (bd_go_s) armpend_r <= 1'b0;
            if (bd_rd_r) armdata_r <= ram_q_r;
            if (armwrite) begin
                case (armwaddr)
                    3'd1: enable_r <= armwdata[31];
                    3'd2: if (!armpend_r) begin
                        armaddr_r <= armwdata[17:0] & AMASK;
                        armpend_r <= 1'b1;
                        armdir_r  <= 1'b0;
                    end
                    3'd3: if (!armpend_r) begin
                        armdata_r <= armwdata[15:0];
                        armpend_r <= 1'b1;
                        armdir_r  <= 1'b1;
                    end
                    default: begin end
                endcase
            end
        end
    end

`ifdef UNIMEM_COUNTERS_EN
    logic [15:0] rdcount_r, wrcount_r;
    logic        rd_inc_s, wr_inc_s;

    assign rd_inc_s = (state_r == ST_READ)  && (state_n_s == ST_DRIVE);
    assign wr_inc_s = (state_r == ST_WRITE) && (state_n_s == ST_HOLD);

    // Saturating bus cycle counters, cleared by any ARM write to register 4
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            rdcount_r <= 16'd0;
            wrcount_r <= 16'd0;
        end else if (armwrite && (armwaddr == 3'd4)) begin
            rdcount_r <= 16'd0;
            wrcount_r <= 16'd0;
        end else begin
            if (rd_inc_s && (rdcount_r != 16'hFFFF)) rdcount_r <= rdcount_r + 16'd1;
            if (wr_inc_s && (wrcount_r != 16'hFFFF)) wrcount_r <= wrcount_r + 16'd1;
        end
    end
`endif

    // ARM register read mux
    always_comb begin
        armrdata = 32'hDEADBEEF;
        case (armraddr)
            3'd0: armrdata = 32'h554D200B;
            3'd1: armrdata = {enable_r, 13'd0, armpend_r, hit_r, 16'd0};
            3'd2: armrdata = {14'd0, armaddr_r};
            3'd3: armrdata = {16'd0, armdata_r};
`ifdef UNIMEM_COUNTERS_EN
            3'd4: armrdata = {rdcount_r, wrcount_r};
`endif
            default: armrdata = 32'hDEADBEEF;
        endcase
    end

endmodule
